// File: rtl/heichips25_accum_alu_pkg.sv
// Shared types for the accumulate ALU: opcode encoding and per-result status flags.
package heichips25_accum_alu_pkg;

   typedef enum logic [1:0] {
      OP_ADD  = 2'b00,
      OP_SUB  = 2'b01,
      OP_ACC  = 2'b10,
      OP_LOAD = 2'b11
   } op_e;

   typedef struct packed {
      logic carry;
      logic ovf;
   } flags_t;

   localparam int unsigned FLAG_W = $bits(flags_t);

endpackage

// File: rtl/heichips25_sync_fifo.sv
// Generic synchronous FIFO; the head entry is read straight from registered storage.
module heichips25_sync_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         head_c,
   output logic                     empty_c,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             full_c;
   logic             do_push;
   logic             do_pop;

   assign full_c  = (count == CW'(DEPTH));
   assign empty_c = (count == '0);
   assign do_push = push & ~full_c;
   assign do_pop  = pop & ~empty_c;
   assign head_c  = mem[rd_ptr];

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            mem[i] <= '0;
         end
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= wr_ptr + AW'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/heichips25_accum_alu.sv
// Add/sub/accumulate unit with valid/ready on both sides and an output result FIFO.
module heichips25_accum_alu
   import heichips25_accum_alu_pkg::*;
#(
   parameter int unsigned WIDTH    = 8,
   parameter int unsigned DEPTH    = 2,
   parameter bit          SATURATE = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       in_op,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             out_carry,
   output logic             out_ovf,
   output logic [WIDTH-1:0] acc_q
);

   localparam int unsigned FW = WIDTH + FLAG_W;
   localparam int unsigned CW = $clog2(DEPTH) + 1;

   op_e              op;
   logic [WIDTH-1:0] opa_c;
   logic [WIDTH-1:0] opb_c;
   logic [WIDTH:0]   sum_c;
   logic [WIDTH:0]   diff_c;
   logic [WIDTH-1:0] res_c;
   flags_t           flags_c;
   flags_t           head_flags_c;
   logic [FW-1:0]    head_c;
   logic             empty_c;
   logic [CW-1:0]    count;
   logic             accept_c;
   logic             pop_c;

   assign op       = op_e'(in_op);
   assign in_ready = (count < CW'(DEPTH));
   assign accept_c = in_valid & in_ready;
   assign pop_c    = out_valid & out_ready;

   // ACC adds operand A to the accumulator; ADD/SUB use both operands.
   always_comb begin
      opa_c   = (op == OP_ACC) ? acc_q : in_a;
      opb_c   = (op == OP_ACC) ? in_a  : in_b;
      sum_c   = {1'b0, opa_c} + {1'b0, opb_c};
      diff_c  = {1'b0, in_a} - {1'b0, in_b};
      res_c   = sum_c[WIDTH-1:0];
      flags_c = '0;
      flags_c.carry = sum_c[WIDTH];
      flags_c.ovf   = (opa_c[WIDTH-1] == opb_c[WIDTH-1]) &&
                      (sum_c[WIDTH-1] != opa_c[WIDTH-1]);
      case (op)
         OP_SUB: begin
            res_c         = diff_c[WIDTH-1:0];
            flags_c.carry = diff_c[WIDTH];
            flags_c.ovf   = (in_a[WIDTH-1] != in_b[WIDTH-1]) &&
                            (diff_c[WIDTH-1] != in_a[WIDTH-1]);
         end
         OP_LOAD: begin
            res_c   = in_a;
            flags_c = '0;
         end
         default: ;
      endcase
      // Clamp on the raw carry/borrow; flags still report the event.
      if (SATURATE && flags_c.carry) begin
         res_c = (op == OP_SUB) ? '0 : '1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         acc_q <= '0;
      end else if (accept_c && (op == OP_ACC || op == OP_LOAD)) begin
         acc_q <= res_c;
      end
   end

   heichips25_sync_fifo #(
      .WIDTH (FW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (accept_c),
      .push_data ({res_c, flags_c}),
      .pop       (pop_c),
      .head_c    (head_c),
      .empty_c   (empty_c),
      .count     (count)
   );

   assign out_valid    = ~empty_c;
   assign out_data     = head_c[FW-1:FLAG_W];
   assign head_flags_c = flags_t'(head_c[FLAG_W-1:0]);
   assign out_carry    = head_flags_c.carry;
   assign out_ovf      = head_flags_c.ovf;

endmodule

// File: tb/tb_heichips25_accum_alu.sv
// Bench for the accumulate ALU: wrap and saturating instances checked against a queue model.
module tb_heichips25_accum_alu;
   import heichips25_accum_alu_pkg::*;

   localparam int W = 8;
   localparam int D = 2;

   typedef struct {
      int d;
      bit c;
      bit o;
   } ent_t;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic         out_ready;
   logic [1:0]   in_op;
   logic [W-1:0] in_a;
   logic [W-1:0] in_b;

   logic         rdy_w, vld_w, car_w, ovf_w;
   logic [W-1:0] dat_w, acc_w;
   logic         rdy_s, vld_s, car_s, ovf_s;
   logic [W-1:0] dat_s, acc_s;

   ent_t q_w[$];
   ent_t q_s[$];
   int   macc_w, macc_s;
   int   n_cmp, n_err;

   always #5 clk = ~clk;

   heichips25_accum_alu #(.WIDTH(W), .DEPTH(D), .SATURATE(1'b0)) dut_wrap (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_w), .in_op(in_op),
      .in_a(in_a), .in_b(in_b), .out_valid(vld_w), .out_ready(out_ready),
      .out_data(dat_w), .out_carry(car_w), .out_ovf(ovf_w), .acc_q(acc_w)
   );

   heichips25_accum_alu #(.WIDTH(W), .DEPTH(D), .SATURATE(1'b1)) dut_sat (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_s), .in_op(in_op),
      .in_a(in_a), .in_b(in_b), .out_valid(vld_s), .out_ready(out_ready),
      .out_data(dat_s), .out_carry(car_s), .out_ovf(ovf_s), .acc_q(acc_s)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int sgn(input int x);
      return (x >= 128) ? x - 256 : x;
   endfunction

   // Reference arithmetic on plain integers.
   function automatic void model(input bit sat, input int op, input int a, input int b,
                                 input int acc, output int r, output bit c, output bit o,
                                 output int nacc);
      int x, y, s;
      nacc = acc;
      r = 0; c = 1'b0; o = 1'b0;
      case (op)
         0, 2: begin
            x = (op == 2) ? acc : a;
            y = (op == 2) ? a : b;
            s = x + y;
            c = (s > 255);
            r = s % 256;
            o = (sgn(x) + sgn(y) > 127) || (sgn(x) + sgn(y) < -128);
            if (sat && c) r = 255;
         end
         1: begin
            c = (a < b);
            r = (a - b + 256) % 256;
            o = (sgn(a) - sgn(b) > 127) || (sgn(a) - sgn(b) < -128);
            if (sat && c) r = 0;
         end
         default: r = a;
      endcase
      if (op == 2 || op == 3) nacc = r;
   endfunction

   task automatic compare(input bit r);
      check("in_ready_wrap", 32'(rdy_w), 32'(q_w.size() < D));
      check("in_ready_sat", 32'(rdy_s), 32'(q_s.size() < D));
      check("out_valid_wrap", 32'(vld_w), 32'(q_w.size() > 0));
      check("out_valid_sat", 32'(vld_s), 32'(q_s.size() > 0));
      check("acc_wrap", 32'(acc_w), 32'(macc_w));
      check("acc_sat", 32'(acc_s), 32'(macc_s));
      if (r) begin
         check("rst_data", 32'({dat_w, car_w, ovf_w}), 32'(0));
         check("rst_data_sat", 32'({dat_s, car_s, ovf_s}), 32'(0));
      end
      if (q_w.size() > 0) begin
         check("data_wrap", 32'(dat_w), 32'(q_w[0].d));
         check("carry_wrap", 32'(car_w), 32'(q_w[0].c));
         check("ovf_wrap", 32'(ovf_w), 32'(q_w[0].o));
      end
      if (q_s.size() > 0) begin
         check("data_sat", 32'(dat_s), 32'(q_s[0].d));
         check("carry_sat", 32'(car_s), 32'(q_s[0].c));
         check("ovf_sat", 32'(ovf_s), 32'(q_s[0].o));
      end
   endtask

   // One clock: drive inputs, predict handshakes from model state, advance, compare.
   task automatic step(input bit r, input bit v, input int op, input int a, input int b,
                       input bit ordy);
      bit   acc_ok, pop_ok;
      ent_t e;
      int   nacc;
      rst       = r;
      in_valid  = v;
      in_op     = 2'(op);
      in_a      = W'(a);
      in_b      = W'(b);
      out_ready = ordy;
      acc_ok = v && (q_w.size() < D);
      pop_ok = ordy && (q_w.size() > 0);
      @(posedge clk);
      #1;
      if (r) begin
         q_w.delete();
         q_s.delete();
         macc_w = 0;
         macc_s = 0;
      end else begin
         if (pop_ok) begin
            q_w.delete(0);
            q_s.delete(0);
         end
         if (acc_ok) begin
            model(1'b0, op, a, b, macc_w, e.d, e.c, e.o, nacc);
            q_w.push_back(e);
            macc_w = nacc;
            model(1'b1, op, a, b, macc_s, e.d, e.c, e.o, nacc);
            q_s.push_back(e);
            macc_s = nacc;
         end
      end
      compare(r);
   endtask

   initial begin
      n_cmp = 0; n_err = 0; macc_w = 0; macc_s = 0;
      rst = 1'b1; in_valid = 1'b1; out_ready = 1'b0; in_op = 2'b00; in_a = '0; in_b = '0;

      // Reset held two cycles with a request pending
      step(1, 1, 0, 1, 2, 1);
      step(1, 1, 0, 1, 2, 1);
      check("reset_in_ready", 32'(rdy_w), 32'(1));
      check("reset_out_valid", 32'(vld_w), 32'(0));

      // ADD with carry out
      step(0, 1, 0, 'hF0, 'h20, 1);
      check("add_wrap_data", 32'(dat_w), 32'h10);
      check("add_wrap_carry", 32'(car_w), 32'(1));
      check("add_sat_data", 32'(dat_s), 32'hFF);

      // SUB with borrow, then signed overflow
      step(0, 1, 1, 'h10, 'h20, 1);
      check("sub_wrap_data", 32'(dat_w), 32'hF0);
      check("sub_wrap_borrow", 32'(car_w), 32'(1));
      check("sub_sat_data", 32'(dat_s), 32'h00);
      step(0, 1, 1, 'h80, 'h01, 1);
      check("sub_ovf_data", 32'(dat_w), 32'h7F);
      check("sub_ovf_flag", 32'(ovf_w), 32'(1));

      // LOAD / ACC chain
      step(0, 1, 3, 'h05, 0, 1);
      step(0, 1, 2, 'h03, 0, 1);
      check("acc_mid", 32'(dat_w), 32'h08);
      step(0, 1, 2, 'h7C, 0, 1);
      check("acc_last_data", 32'(dat_w), 32'h84);
      check("acc_last_ovf", 32'(ovf_w), 32'(1));
      check("acc_last_carry", 32'(car_w), 32'(0));
      check("acc_q_final", 32'(acc_w), 32'h84);
      step(0, 0, 0, 0, 0, 1);

      // Backpressure: third request held until a slot frees
      step(0, 1, 0, 1, 1, 0);
      step(0, 1, 0, 2, 2, 0);
      check("bp_full", 32'(rdy_w), 32'(0));
      step(0, 1, 0, 3, 3, 0);
      check("bp_held_head", 32'(dat_w), 32'h02);
      step(0, 1, 0, 3, 3, 1);
      check("bp_after_pop_ready", 32'(rdy_w), 32'(1));
      check("bp_second_head", 32'(dat_w), 32'h04);
      step(0, 1, 0, 3, 3, 1);
      check("bp_pushpop_head", 32'(dat_w), 32'h06);
      check("bp_pushpop_ready", 32'(rdy_w), 32'(1));
      step(0, 0, 0, 0, 0, 1);

      // Reset with two entries queued and acc=0x08
      step(0, 1, 3, 'h05, 0, 0);
      step(0, 1, 2, 'h03, 0, 0);
      check("pre_rst_acc", 32'(acc_w), 32'h08);
      step(1, 1, 2, 'h09, 0, 0);
      check("mid_rst_valid", 32'(vld_w), 32'(0));
      check("mid_rst_acc", 32'(acc_w), 32'(0));
      step(0, 0, 0, 0, 0, 1);
      check("mid_rst_no_accept", 32'(vld_w), 32'(0));

      // Random traffic with occasional resets
      for (int i = 0; i < 500; i++) begin
         int a, b;
         a = int'($urandom_range(0, 255));
         b = int'($urandom_range(0, 255));
         if ($urandom_range(0, 7) == 0) a = 255;
         if ($urandom_range(0, 7) == 0) b = 128;
         step($urandom_range(0, 59) == 0, $urandom_range(0, 3) != 0,
              int'($urandom_range(0, 3)), a, b, $urandom_range(0, 2) != 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
